adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 19 +
 rtl/adder_arbiter_cbadder.sv | 41 ++++
 rtl/adder_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared sizing defaults and FSM encoding for the shared-adder arbiter.
package adder_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT  = 4;
    localparam int WIDTH_DEFAULT    = 32;
    localparam int ID_WIDTH_DEFAULT = $clog2(NUM_REQ_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_cbadder.sv
// Carry-bypass adder: ripple inside fixed-size blocks, with each block's
// carry-in forwarded straight to its carry-out when every bit propagates.
module CBAdder_32 #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
)(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK;

    logic carry;
    logic block_cin;
    logic all_prop;
    logic bit_prop;

    always_comb begin
        sum       = '0;
        carry     = cin;
        block_cin = cin;
        all_prop  = 1'b1;
        bit_prop  = 1'b0;
        for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
            block_cin = carry;
            all_prop  = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                bit_prop = a[blk*BLOCK + j] ^ b[blk*BLOCK + j];
                sum[blk*BLOCK + j] = bit_prop ^ carry;
                carry    = (a[blk*BLOCK + j] & b[blk*BLOCK + j]) | (bit_prop & carry);
                all_prop = all_prop & bit_prop;
            end
            carry = all_prop ? block_cin : carry;
        end
        cout = carry;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one carry-bypass adder among several
// requesters, one operation in flight, with a registered valid/ready response.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    input  logic [NUM_REQ-1:0]          req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_width(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]            rsp_sum,
    output logic                        rsp_cout,
    output logic                        rsp_overflow
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            accept;
    int              cand;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [ID_W-1:0]  op_id;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // Search upward from the requester just after the last winner, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(last_grant) + 1 + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_found && !rst) begin
                    accept              = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_next          = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                state_next = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operands are snapshotted at grant so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= ID_W'(NUM_REQ - 1);
            op_a         <= '0;
            op_b         <= '0;
            op_cin       <= 1'b0;
            op_id        <= '0;
            rsp_id       <= '0;
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                op_id      <= grant_id;
                op_a       <= req_a[grant_id*WIDTH +: WIDTH];
                op_b       <= req_b[grant_id*WIDTH +: WIDTH];
                op_cin     <= req_cin[grant_id];
            end
            if (state == ST_COMPUTE) begin
                rsp_id       <= op_id;
                rsp_sum      <= add_sum;
                rsp_cout     <= add_cout;
                rsp_overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
        end
    end

    CBAdder_32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter: latency, arithmetic, fairness,
// backpressure, operand isolation and reset behaviour.
module tb_adder_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_overflow;

    int vectors;
    int miscompares;

    adder_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i]        = c;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        req_valid = 4'hF;
        #2;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected %b", req_ready, 4'b0000);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%b id=%0d sum=%h c=%b o=%b expected all zero",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
        end
        step();
        step();
        req_valid = 4'h0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL ovf_grant: got %b expected %b", req_ready, 4'b0001);
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_early_valid: got %b expected 0", rsp_valid);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== {1'b1, 2'd0, 32'h8000_0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL ovf_result: got v=%b id=%0d sum=%h c=%b o=%b expected v=1 id=0 sum=80000000 c=0 o=1",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_release: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'(i), 32'd10, 1'b0);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int op = 0; op < 4; op++) begin
            vectors++;
            if (req_ready !== 4'(1 << op)) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got %b expected %b", op, req_ready, 4'(1 << op));
            end
            step();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_compute%0d: got valid=%b expected 0", op, rsp_valid);
            end
            step();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'(op), 32'(10 + op)}) begin
                miscompares++;
                $display("[TB] FAIL rr_result%0d: got v=%b id=%0d sum=%h expected v=1 id=%0d sum=%h",
                         op, rsp_valid, rsp_id, rsp_sum, op, 32'(10 + op));
            end
            step();
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        set_req(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL bp_grant: got %b expected %b", req_ready, 4'b0100);
        end
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        step();
        set_req(0, 32'd1, 32'd1, 1'b0);
        req_valid = 4'b0001;
        for (int h = 0; h < 5; h++) begin
            #1;
            vectors++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, req_ready} !==
                {1'b1, 2'd2, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'b0000}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d sum=%h c=%b o=%b rdy=%b expected v=1 id=2 sum=7fffffff c=1 o=1 rdy=0000",
                         h, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL bp_next_grant: got %b expected %b", req_ready, 4'b0001);
        end
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL bp_withdraw: got %b expected %b", req_ready, 4'b0000);
        end
        step();
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_no_phantom: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_operand_change();
        set_req(1, 32'hFFFF_FC19, 32'h0000_03E7, 1'b0);
        req_valid = 4'b0010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL opchg_grant: got %b expected %b", req_ready, 4'b0010);
        end
        step();
        req_valid = 4'b0000;
        set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== {1'b1, 2'd1, 32'h0000_0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL opchg_result: got v=%b id=%0d sum=%h c=%b o=%b expected v=1 id=1 sum=00000000 c=1 o=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_req(1, 32'd5, 32'd6, 1'b0);
        req_valid = 4'b0010;
        #1;
        step();
        req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, req_ready} !== 41'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got v=%b id=%0d sum=%h c=%b o=%b rdy=%b expected all zero",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, req_ready);
        end
        set_req(0, 32'd100, 32'd23, 1'b1);
        set_req(2, 32'd7, 32'd8, 1'b0);
        req_valid = 4'b0101;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midrst_ready_in_reset: got %b expected %b", req_ready, 4'b0000);
        end
        step();
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_response: got valid=%b expected 0", rsp_valid);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL midrst_first_grant: got %b expected %b", req_ready, 4'b0001);
        end
        step();
        req_valid = 4'b0000;
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== {1'b1, 2'd0, 32'h0000_007C, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL midrst_result: got v=%b id=%0d sum=%h c=%b o=%b expected v=1 id=0 sum=0000007c c=0 o=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [3:0] exp_grant [6];
        int         grants;
        int         req3_grants;
        exp_grant   = '{4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
        grants      = 0;
        req3_grants = 0;
        rsp_ready   = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            req_valid = {1'b1, 2'b00, (cyc % 2 == 0)};
            #1;
            if (req_ready !== 4'b0000) begin
                vectors++;
                if (grants >= 6) begin
                    miscompares++;
                    $display("[TB] FAIL starve_extra_grant: got %b at cycle %0d expected none", req_ready, cyc);
                end else if (req_ready !== exp_grant[grants]) begin
                    miscompares++;
                    $display("[TB] FAIL starve_grant%0d: got %b expected %b", grants, req_ready, exp_grant[grants]);
                end
                if (req_ready === 4'b1000) begin
                    req3_grants++;
                end
                grants++;
            end
            step();
        end
        req_valid = 4'b0000;
        vectors++;
        if (grants != 6) begin
            miscompares++;
            $display("[TB] FAIL starve_grant_count: got %0d expected 6", grants);
        end
        vectors++;
        if (req3_grants != 4) begin
            miscompares++;
            $display("[TB] FAIL starve_req3_count: got %0d expected 4", req3_grants);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        req_valid   = 4'h0;
        req_a       = '0;
        req_b       = '0;
        req_cin     = 4'h0;
        rsp_ready   = 1'b1;

        test_reset();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        test_starvation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
